// File: rtl/prefetch_cache_read_arbiter.sv
// prefetch_cache_read_arbiter: round-robin sharing of one cache read port with per-read timeout
module prefetch_cache_read_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [32*NUM_REQ-1:0]  addr_i,
  output logic [NUM_REQ-1:0]     gnt_o,
  output logic [NUM_REQ-1:0]     rvalid_o,
  output logic [31:0]            rdata_o,
  output logic                   err_o,
  output logic                   cache_data_req_o,
  output logic [31:0]            cache_r_addr_o,
  input  logic                   wait_cache,
  input  logic                   cache_data_ready,
  input  logic [31:0]            cache_data_i,
  output logic                   busy_o,
  output logic [1:0]             state_o
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, RETURN} state_t;
  state_t state;
  logic [PW-1:0] ptr, owner, pick, idx;
  logic [CW-1:0] cnt;
  logic done, tmo;
  // scan downward so the requester closest to ptr is the last (winning) assignment
  always_comb begin
    pick = '0;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr) + i) % NUM_REQ);
      if (req_i[idx]) pick = idx;
    end
  end
  assign done = (state == ISSUE && !wait_cache && cache_data_ready) || (state == WAIT_DATA && cache_data_ready);
  assign tmo = cnt == CW'(TIMEOUT_CYCLES - 1);
  assign busy_o = state != IDLE;
  assign state_o = state;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr <= '0;
      owner <= '0;
      cnt <= '0;
      gnt_o <= '0;
      rvalid_o <= '0;
      rdata_o <= '0;
      err_o <= 1'b0;
      cache_data_req_o <= 1'b0;
      cache_r_addr_o <= '0;
    end else begin
      gnt_o <= '0;
      rvalid_o <= '0;
      case (state)
        IDLE: if (|req_i) begin
          owner <= pick;
          gnt_o <= NUM_REQ'(1) << pick;
          cache_data_req_o <= 1'b1;
          cache_r_addr_o <= addr_i[32*pick +: 32];
          cnt <= '0;
          state <= ISSUE;
        end
        ISSUE, WAIT_DATA: begin
          cnt <= cnt + 1'b1;
          if (state == ISSUE && !wait_cache) begin
            cache_data_req_o <= 1'b0;
            state <= WAIT_DATA;
          end
          // completion beats timeout when both land on the same edge
          if (done || tmo) begin
            cache_data_req_o <= 1'b0;
            rvalid_o <= NUM_REQ'(1) << owner;
            rdata_o <= done ? cache_data_i : '0;
            err_o <= !done;
            state <= RETURN;
          end
        end
        default: begin
          ptr <= (owner == PW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_prefetch_cache_read_arbiter.sv
// tb_prefetch_cache_read_arbiter: directed checks of grant order, stalls, timeout and reset
module tb_prefetch_cache_read_arbiter;
  logic clk = 0, reset = 0;
  logic [3:0] req_i = '0;
  logic [127:0] addr_i = {32'h400, 32'h300, 32'h200, 32'h100};
  logic [3:0] gnt_o, rvalid_o;
  logic [31:0] rdata_o, cache_r_addr_o, cache_data_i = '0;
  logic err_o, cache_data_req_o, busy_o;
  logic wait_cache = 0, cache_data_ready = 0;
  logic [1:0] state_o;
  int checks = 0, errors = 0;
  prefetch_cache_read_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .addr_i(addr_i), .gnt_o(gnt_o),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o), .cache_data_req_o(cache_data_req_o),
    .cache_r_addr_o(cache_r_addr_o), .wait_cache(wait_cache), .cache_data_ready(cache_data_ready),
    .cache_data_i(cache_data_i), .busy_o(busy_o), .state_o(state_o));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, gnt_o, 0);
    chk({tag, "_rvalid"}, rvalid_o, 0);
    chk({tag, "_rdata"}, rdata_o, 0);
    chk({tag, "_err"}, err_o, 0);
    chk({tag, "_creq"}, cache_data_req_o, 0);
    chk({tag, "_caddr"}, cache_r_addr_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_state"}, state_o, 0);
  endtask
  task automatic txn(input logic [3:0] g, input logic [31:0] a, input logic [31:0] d);
    cyc();
    chk("gnt", gnt_o, g);
    chk("creq", cache_data_req_o, 1);
    chk("caddr", cache_r_addr_o, a);
    chk("busy", busy_o, 1);
    req_i = req_i & ~g;
    cyc();
    chk("gnt_pulse", gnt_o, 0);
    chk("creq_drop", cache_data_req_o, 0);
    chk("wait_state", state_o, 2);
    cache_data_ready = 1;
    cache_data_i = d;
    cyc();
    chk("rvalid", rvalid_o, g);
    chk("rdata", rdata_o, d);
    chk("err", err_o, 0);
    chk("ret_state", state_o, 3);
    cache_data_ready = 0;
    cyc();
    chk("idle_state", state_o, 0);
    chk("rvalid_pulse", rvalid_o, 0);
    chk("rdata_hold", rdata_o, d);
  endtask
  task automatic tmo(input logic [3:0] g, input logic late_ready, input logic [31:0] d);
    cyc();
    chk("tmo_gnt", gnt_o, g);
    req_i = '0;
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk("tmo_quiet", rvalid_o, 0);
    end
    cache_data_ready = late_ready;
    cache_data_i = d;
    cyc();
    chk("tmo_rvalid", rvalid_o, g);
    chk("tmo_err", err_o, !late_ready);
    chk("tmo_rdata", rdata_o, late_ready ? d : 0);
    chk("tmo_creq", cache_data_req_o, 0);
    cache_data_ready = 0;
    cyc();
    chk("tmo_idle", state_o, 0);
  endtask
  initial begin
    cyc();
    chk_zero("rst");
    reset = 1;
    cyc();
    req_i = 4'b0001;
    txn(4'b0001, 32'h100, 32'hDEAD);
    req_i = 4'b0010;
    wait_cache = 1;
    cyc();
    chk("stall_gnt", gnt_o, 4'b0010);
    chk("stall_addr0", cache_r_addr_o, 32'h200);
    req_i = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_creq", cache_data_req_o, 1);
      chk("stall_addr", cache_r_addr_o, 32'h200);
      chk("stall_no_gnt", gnt_o, 0);
    end
    req_i = '0;
    wait_cache = 0;
    cache_data_ready = 1;
    cache_data_i = 32'hBEEF;
    cyc();
    chk("fast_rvalid", rvalid_o, 4'b0010);
    chk("fast_rdata", rdata_o, 32'hBEEF);
    chk("fast_creq", cache_data_req_o, 0);
    cache_data_ready = 0;
    cyc();
    req_i = 4'b0011;
    txn(4'b0001, 32'h100, 32'h11);
    txn(4'b0010, 32'h200, 32'h22);
    req_i = 4'b1000;
    txn(4'b1000, 32'h400, 32'h33);
    reset = 0;
    cyc();
    reset = 1;
    req_i = 4'b1111;
    txn(4'b0001, 32'h100, 32'h40);
    txn(4'b0010, 32'h200, 32'h41);
    txn(4'b0100, 32'h300, 32'h42);
    txn(4'b1000, 32'h400, 32'h43);
    req_i = 4'b1001;
    txn(4'b0001, 32'h100, 32'h44);
    req_i = 4'b0100;
    tmo(4'b0100, 0, 32'h0);
    req_i = 4'b0001;
    txn(4'b0001, 32'h100, 32'h5555);
    req_i = 4'b0010;
    tmo(4'b0010, 1, 32'h6666);
    req_i = 4'b0100;
    cyc();
    chk("r6_gnt", gnt_o, 4'b0100);
    req_i = '0;
    cyc();
    chk("r6_wait", state_o, 2);
    #2 reset = 0;
    #1 chk_zero("r6");
    cache_data_ready = 1;
    cache_data_i = 32'h7777;
    cyc();
    reset = 1;
    cyc();
    chk("r6_ign_rvalid", rvalid_o, 0);
    chk("r6_ign_state", state_o, 0);
    cache_data_ready = 0;
    req_i = 4'b1001;
    txn(4'b0001, 32'h100, 32'h88);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
